// File: rtl/d_cache_nway.sv
// N-way set-associative write-back/write-allocate data cache with multi-word lines and tree pLRU.
// Define DCACHE_UNCACHED_EN to let addresses with addr[31:29]==3'b101 bypass the cache.
module d_cache_nway #(
  parameter int WAYS        = 4,
  parameter int INDEX_WIDTH = 6,
  parameter int LINE_WORDS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_data_req,
  input  logic        cpu_data_wr,
  input  logic [1:0]  cpu_data_size,
  input  logic [31:0] cpu_data_addr,
  input  logic [31:0] cpu_data_wdata,
  output logic [31:0] cpu_data_rdata,
  output logic        cpu_data_addr_ok,
  output logic        cpu_data_data_ok,
  output logic        cache_data_req,
  output logic        cache_data_wr,
  output logic [1:0]  cache_data_size,
  output logic [31:0] cache_data_addr,
  output logic [31:0] cache_data_wdata,
  input  logic [31:0] cache_data_rdata,
  input  logic        cache_data_addr_ok,
  input  logic        cache_data_data_ok
);
  localparam int SETS         = 1 << INDEX_WIDTH;
  localparam int WORD_BITS    = $clog2(LINE_WORDS);
  localparam int OFFSET_WIDTH = WORD_BITS + 2;
  localparam int TAG_WIDTH    = 32 - INDEX_WIDTH - OFFSET_WIDTH;
  localparam int CNT_W        = (WORD_BITS > 0) ? WORD_BITS : 1;
  localparam int WAY_W        = $clog2(WAYS);
  localparam int LEVELS       = WAY_W;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LINE_WORDS - 1);

`ifdef DCACHE_UNCACHED_EN
  typedef enum logic [1:0] {IDLE, WB, RF, UC} state_t;
`else
  typedef enum logic [1:0] {IDLE, WB, RF} state_t;
`endif

  state_t state_q, state_d;

  logic [WAYS-1:0]      valid_q [SETS];
  logic [WAYS-1:0]      dirty_q [SETS];
  logic [WAYS-2:0]      plru_q  [SETS];
  logic [TAG_WIDTH-1:0] tag_q   [SETS][WAYS];
  logic [31:0]          data_q  [SETS][WAYS][LINE_WORDS];

  logic [CNT_W-1:0]       cnt_q;
  logic                   wait_q;
  logic [INDEX_WIDTH-1:0] index_r;
  logic [TAG_WIDTH-1:0]   tag_r;
  logic [WAY_W-1:0]       victim_r;
  logic [TAG_WIDTH-1:0]   victim_tag_r;

  logic [TAG_WIDTH-1:0]   cpu_tag;
  logic [INDEX_WIDTH-1:0] cpu_index;
  logic [CNT_W-1:0]       cpu_word;
  logic                   hit, has_invalid, victim_dirty;
  logic [WAY_W-1:0]       hit_way, victim_way;
  logic [31:0]            hit_word, store_word;
  logic [3:0]             mask;
  logic                   req_active, xfer_done, hit_access, miss_start, fill_last;
  logic [31:0]            wb_addr, rf_addr;

  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] bits);
    logic [WAYS-2:0] sh;
    int node;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      sh = bits >> node;
      node = 2 * node + 1 + int'(sh[0]);
    end
    return WAY_W'(node - (WAYS - 1));
  endfunction

  // Walk root to leaf, leaving each node pointing at the half not just accessed.
  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] bits,
                                                 input logic [WAY_W-1:0] way);
    logic [WAYS-2:0]  r, sel;
    logic [WAY_W-1:0] sh;
    int node;
    r = bits;
    node = 0;
    for (int l = 0; l < LEVELS; l++) begin
      sh   = way >> (LEVELS - 1 - l);
      sel  = (WAYS-1)'(1) << node;
      r    = sh[0] ? (r & ~sel) : (r | sel);
      node = 2 * node + 1 + int'(sh[0]);
    end
    return r;
  endfunction

  function automatic logic [3:0] byte_mask(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b00:   return 4'b0001 << a;
      2'b01:   return a[1] ? 4'b1100 : 4'b0011;
      default: return 4'b1111;
    endcase
  endfunction

  assign cpu_tag   = cpu_data_addr[31 -: TAG_WIDTH];
  assign cpu_index = cpu_data_addr[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_word  = CNT_W'(cpu_data_addr[31:2] & 30'(LINE_WORDS - 1));

  always_comb begin
    hit = 1'b0;
    hit_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!hit && valid_q[cpu_index][w] && tag_q[cpu_index][w] == cpu_tag) begin
        hit = 1'b1;
        hit_way = WAY_W'(w);
      end
    end
  end

  always_comb begin
    has_invalid = 1'b0;
    victim_way = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (!has_invalid && !valid_q[cpu_index][w]) begin
        has_invalid = 1'b1;
        victim_way = WAY_W'(w);
      end
    end
    if (!has_invalid) victim_way = plru_victim(plru_q[cpu_index]);
  end

  assign victim_dirty = valid_q[cpu_index][victim_way] && dirty_q[cpu_index][victim_way];
  assign hit_word     = data_q[cpu_index][hit_way][cpu_word];
  assign mask         = byte_mask(cpu_data_size, cpu_data_addr[1:0]);

  always_comb begin
    store_word = hit_word;
    for (int b = 0; b < 4; b++)
      if (mask[b]) store_word[8*b +: 8] = cpu_data_wdata[8*b +: 8];
  end

  // Valid/ready on the lower port: req is held until addr_ok, then stays low
  // (wait_q) until data_ok so only one transaction is ever outstanding.
  assign req_active = (state_q != IDLE) && !wait_q;
  assign xfer_done  = cache_data_data_ok && (wait_q || (req_active && cache_data_addr_ok));
  assign fill_last  = (state_q == RF) && xfer_done && (cnt_q == LAST_CNT);
  assign wb_addr    = {victim_tag_r, index_r, {OFFSET_WIDTH{1'b0}}} | (32'(cnt_q) << 2);
  assign rf_addr    = {tag_r, index_r, {OFFSET_WIDTH{1'b0}}} | (32'(cnt_q) << 2);
  assign cache_data_req = req_active;

`ifdef DCACHE_UNCACHED_EN
  logic uncached;
  assign uncached = (cpu_data_addr[31:29] == 3'b101);
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d          = state_q;
    cpu_data_addr_ok = 1'b0;
    cpu_data_data_ok = 1'b0;
    cpu_data_rdata   = hit_word;
    cache_data_wr    = 1'b0;
    cache_data_size  = 2'b00;
    cache_data_addr  = 32'h0;
    cache_data_wdata = 32'h0;
    hit_access       = 1'b0;
    miss_start       = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_data_req) begin
`ifdef DCACHE_UNCACHED_EN
          if (uncached) state_d = UC;
          else
`endif
          if (hit) begin
            cpu_data_addr_ok = 1'b1;
            cpu_data_data_ok = 1'b1;
            hit_access       = 1'b1;
          end else begin
            miss_start = 1'b1;
            state_d    = victim_dirty ? WB : RF;
          end
        end
      end
      WB: begin
        cache_data_wr    = 1'b1;
        cache_data_size  = 2'b10;
        cache_data_addr  = wb_addr;
        cache_data_wdata = data_q[index_r][victim_r][cnt_q];
        if (xfer_done && cnt_q == LAST_CNT) state_d = RF;
      end
      RF: begin
        cache_data_size = 2'b10;
        cache_data_addr = rf_addr;
        if (fill_last) state_d = IDLE;
      end
`ifdef DCACHE_UNCACHED_EN
      UC: begin
        cache_data_wr    = cpu_data_wr;
        cache_data_size  = cpu_data_size;
        cache_data_addr  = cpu_data_addr;
        cache_data_wdata = cpu_data_wdata;
        cpu_data_addr_ok = req_active && cache_data_addr_ok;
        cpu_data_data_ok = cache_data_data_ok;
        cpu_data_rdata   = cache_data_rdata;
        if (xfer_done) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q        <= '0;
      wait_q       <= 1'b0;
      index_r      <= '0;
      tag_r        <= '0;
      victim_r     <= '0;
      victim_tag_r <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_q[s] <= '0;
        dirty_q[s] <= '0;
        plru_q[s]  <= '0;
      end
    end else begin
      if (xfer_done)                            wait_q <= 1'b0;
      else if (req_active && cache_data_addr_ok) wait_q <= 1'b1;
      if (miss_start) begin
        index_r      <= cpu_index;
        tag_r        <= cpu_tag;
        victim_r     <= victim_way;
        victim_tag_r <= tag_q[cpu_index][victim_way];
      end
      if (xfer_done && (state_q == WB || state_q == RF))
        cnt_q <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
      if (hit_access) begin
        plru_q[cpu_index] <= plru_touch(plru_q[cpu_index], hit_way);
        if (cpu_data_wr) dirty_q[cpu_index][hit_way] <= 1'b1;
      end
      if (fill_last) begin
        valid_q[index_r][victim_r] <= 1'b1;
        dirty_q[index_r][victim_r] <= 1'b0;
        plru_q[index_r]            <= plru_touch(plru_q[index_r], victim_r);
      end
    end
  end

  // Line storage needs no reset; valid bits gate every use of it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (hit_access && cpu_data_wr) data_q[cpu_index][hit_way][cpu_word] <= store_word;
      if (state_q == RF && xfer_done) data_q[index_r][victim_r][cnt_q] <= cache_data_rdata;
      if (fill_last) tag_q[index_r][victim_r] <= tag_r;
    end
  end
endmodule

// File: tb/tb_d_cache_nway.sv
// Directed bench for d_cache_nway: table of core accesses plus hand sequences
// for fills, write-back eviction, mid-refill reset and the uncached window.
module tb_d_cache_nway;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_data_req, cpu_data_wr;
  logic [1:0]  cpu_data_size;
  logic [31:0] cpu_data_addr, cpu_data_wdata, cpu_data_rdata;
  logic        cpu_data_addr_ok, cpu_data_data_ok;
  logic        cache_data_req, cache_data_wr;
  logic [1:0]  cache_data_size;
  logic [31:0] cache_data_addr, cache_data_wdata, cache_data_rdata;
  logic        cache_data_addr_ok, cache_data_data_ok;

  always #5 clk = ~clk;

  d_cache_nway #(.WAYS(4), .INDEX_WIDTH(6), .LINE_WORDS(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_data_req(cpu_data_req), .cpu_data_wr(cpu_data_wr),
    .cpu_data_size(cpu_data_size), .cpu_data_addr(cpu_data_addr),
    .cpu_data_wdata(cpu_data_wdata), .cpu_data_rdata(cpu_data_rdata),
    .cpu_data_addr_ok(cpu_data_addr_ok), .cpu_data_data_ok(cpu_data_data_ok),
    .cache_data_req(cache_data_req), .cache_data_wr(cache_data_wr),
    .cache_data_size(cache_data_size), .cache_data_addr(cache_data_addr),
    .cache_data_wdata(cache_data_wdata), .cache_data_rdata(cache_data_rdata),
    .cache_data_addr_ok(cache_data_addr_ok), .cache_data_data_ok(cache_data_data_ok)
  );

  typedef struct {
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cycles;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int done_cnt = 0;
  logic [31:0] mem [logic [31:0]];
  logic [66:0] log_q[$];
  logic [66:0] exp_q[$];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'hC0DE_0000;
  endfunction

  // Lower-level slave: accepts an address, returns data the following cycle.
  initial begin
    logic        p_wr;
    logic [31:0] p_addr, p_wdata;
    bit          busy;
    mem[32'h100] = 32'h11;
    mem[32'h104] = 32'h22;
    mem[32'h108] = 32'h33;
    mem[32'h10C] = 32'h44;
    cache_data_addr_ok = 1'b0;
    cache_data_data_ok = 1'b0;
    cache_data_rdata   = 32'h0;
    busy = 0;
    p_wr = 1'b0; p_addr = 32'h0; p_wdata = 32'h0;
    forever begin
      @(posedge clk);
      #2;
      cache_data_addr_ok = 1'b0;
      cache_data_data_ok = 1'b0;
      if (rst) begin
        busy = 0;
      end else if (busy) begin
        cache_data_data_ok = 1'b1;
        if (p_wr) mem[p_addr] = p_wdata;
        else      cache_data_rdata = mem_rd(p_addr);
        busy = 0;
        done_cnt++;
      end else if (cache_data_req) begin
        cache_data_addr_ok = 1'b1;
        busy    = 1;
        p_wr    = cache_data_wr;
        p_addr  = cache_data_addr;
        p_wdata = cache_data_wdata;
        log_q.push_back({cache_data_wr, cache_data_size, cache_data_addr,
                         cache_data_wr ? cache_data_wdata : 32'h0});
      end
    end
  end

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_q.push_back({wr, 2'b10, addr, data});
  endtask

  task automatic check_log(input string name, input int base);
    check_int({name, "_count"}, log_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (base + i < log_q.size()) begin
        tests++;
        if (log_q[base+i] !== exp_q[i]) begin
          fails++;
          $display("FAIL %s[%0d]: got wr/size/addr/data %h expected %h",
                   name, i, log_q[base+i], exp_q[i]);
        end
      end
    end
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cpu_data_req = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Called and returns at 1 time unit after a rising edge. cyc counts the
  // edges passed before data_ok is seen; a hit gives 0.
  task automatic cpu_access(input logic wr, input logic [1:0] size, input logic [31:0] addr,
                            input logic [31:0] wdata, output logic [31:0] rd, output int cyc);
    bit done;
    done = 0;
    cyc  = -1;
    rd   = 32'h0;
    cpu_data_req = 1'b1; cpu_data_wr = wr; cpu_data_size = size;
    cpu_data_addr = addr; cpu_data_wdata = wdata;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (cpu_data_data_ok) begin
        done = 1;
        cyc  = i;
        rd   = cpu_data_rdata;
      end
      @(posedge clk);
      #1;
    end
    cpu_data_req = 1'b0;
    tests++;
    if (!done) begin
      fails++;
      $display("FAIL access_done addr=%h: got no data_ok expected one within 100 cycles", addr);
    end
  endtask

  task automatic rd_chk(input string name, input logic [31:0] addr, input logic [31:0] exp_rd,
                        input int exp_cyc);
    logic [31:0] rd;
    int cyc;
    cpu_access(1'b0, 2'b10, addr, 32'h0, rd, cyc);
    check_int({name, "_cycles"}, cyc, exp_cyc);
    check32({name, "_rdata"}, rd, exp_rd);
  endtask

  vec_t vecs[8];

  initial begin
    logic [31:0] rd;
    int cyc, base, guard;

    rst = 1'b1;
    cpu_data_req = 1'b0; cpu_data_wr = 1'b0; cpu_data_size = 2'b00;
    cpu_data_addr = 32'h0; cpu_data_wdata = 32'h0;

    vecs[0] = '{1'b0, 2'b10, 32'h100, 32'h0,         32'h0000_0011, 9};
    vecs[1] = '{1'b0, 2'b10, 32'h108, 32'h0,         32'h0000_0033, 0};
    vecs[2] = '{1'b1, 2'b00, 32'h101, 32'h0000_AB00, 32'h0,         0};
    vecs[3] = '{1'b0, 2'b10, 32'h100, 32'h0,         32'h0000_AB11, 0};
    vecs[4] = '{1'b1, 2'b01, 32'h10E, 32'hBEEF_0000, 32'h0,         0};
    vecs[5] = '{1'b0, 2'b10, 32'h10C, 32'h0,         32'hBEEF_0044, 0};
    vecs[6] = '{1'b0, 2'b10, 32'h500, 32'h0,         32'hC0DE_0500, 9};
    vecs[7] = '{1'b0, 2'b10, 32'h104, 32'h0,         32'h0000_0022, 0};

    do_reset();
    check32("rst_addr_ok", 32'(cpu_data_addr_ok), 32'h0);
    check32("rst_data_ok", 32'(cpu_data_data_ok), 32'h0);
    check32("rst_lower_req", 32'(cache_data_req), 32'h0);
    check32("rst_lower_wr", 32'(cache_data_wr), 32'h0);
    check32("rst_lower_size", 32'(cache_data_size), 32'h0);
    check32("rst_lower_addr", cache_data_addr, 32'h0);
    check32("rst_lower_wdata", cache_data_wdata, 32'h0);

    // Cold fill, hits, byte/half store merge.
    base = log_q.size();
    for (int i = 0; i < 8; i++) begin
      cpu_access(vecs[i].wr, vecs[i].size, vecs[i].addr, vecs[i].wdata, rd, cyc);
      check_int($sformatf("vec%0d_cycles", i), cyc, vecs[i].exp_cycles);
      if (!vecs[i].wr) check32($sformatf("vec%0d_rdata", i), rd, vecs[i].exp_rdata);
    end
    for (int w = 0; w < 4; w++) push_exp(1'b0, 32'h100 + 32'(4*w), 32'h0);
    for (int w = 0; w < 4; w++) push_exp(1'b0, 32'h500 + 32'(4*w), 32'h0);
    check_log("fill_trace", base);

    // Clean eviction: pLRU picks way 2 (line 0x900).
    do_reset();
    rd_chk("e_100", 32'h100, 32'h11, 9);
    rd_chk("e_500", 32'h500, 32'hC0DE_0500, 9);
    rd_chk("e_900", 32'h900, 32'hC0DE_0900, 9);
    rd_chk("e_D00", 32'hD00, 32'hC0DE_0D00, 9);
    rd_chk("e_100b", 32'h100, 32'h11, 0);
    base = log_q.size();
    rd_chk("e_1100", 32'h1100, 32'hC0DE_1100, 9);
    for (int w = 0; w < 4; w++) push_exp(1'b0, 32'h1100 + 32'(4*w), 32'h0);
    check_log("clean_evict", base);
    rd_chk("e_500_kept", 32'h500, 32'hC0DE_0500, 0);
    rd_chk("e_900_gone", 32'h900, 32'hC0DE_0900, 9);

    // Dirty eviction: line 0x900 written back before the refill.
    do_reset();
    rd_chk("d_100", 32'h100, 32'h11, 9);
    rd_chk("d_500", 32'h500, 32'hC0DE_0500, 9);
    cpu_access(1'b1, 2'b10, 32'h900, 32'hDEAD_BEEF, rd, cyc);
    check_int("d_sw900_cycles", cyc, 9);
    rd_chk("d_D00", 32'hD00, 32'hC0DE_0D00, 9);
    rd_chk("d_100b", 32'h100, 32'h11, 0);
    base = log_q.size();
    rd_chk("d_1100", 32'h1100, 32'hC0DE_1100, 17);
    push_exp(1'b1, 32'h900, 32'hDEAD_BEEF);
    push_exp(1'b1, 32'h904, 32'hC0DE_0904);
    push_exp(1'b1, 32'h908, 32'hC0DE_0908);
    push_exp(1'b1, 32'h90C, 32'hC0DE_090C);
    for (int w = 0; w < 4; w++) push_exp(1'b0, 32'h1100 + 32'(4*w), 32'h0);
    check_log("dirty_evict", base);
    rd_chk("d_900_back", 32'h900, 32'hDEAD_BEEF, 9);

    // Reset after the second refill word abandons the line.
    do_reset();
    base = done_cnt;
    cpu_data_req = 1'b1; cpu_data_wr = 1'b0; cpu_data_size = 2'b10;
    cpu_data_addr = 32'h100; cpu_data_wdata = 32'h0;
    guard = 0;
    while (done_cnt < base + 2 && guard < 100) begin
      @(posedge clk);
      guard++;
    end
    check_int("mid_rf_reached", int'(done_cnt >= base + 2), 1);
    #1;
    check32("mid_rf_req_before", 32'(cache_data_req), 32'h1);
    rst = 1'b1;
    cpu_data_req = 1'b0;
    @(posedge clk);
    #1;
    check32("mid_rf_req_after_rst", 32'(cache_data_req), 32'h0);
    rst = 1'b0;
    base = log_q.size();
    rd_chk("mid_rf_remiss", 32'h100, 32'h11, 9);
    for (int w = 0; w < 4; w++) push_exp(1'b0, 32'h100 + 32'(4*w), 32'h0);
    check_log("mid_rf_refill", base);

    // Uncached window.
    do_reset();
    base = log_q.size();
`ifdef DCACHE_UNCACHED_EN
    rd_chk("uc_first", 32'hA000_0100, 32'h60DE_0100, 2);
    rd_chk("uc_second", 32'hA000_0100, 32'h60DE_0100, 2);
    push_exp(1'b0, 32'hA000_0100, 32'h0);
    push_exp(1'b0, 32'hA000_0100, 32'h0);
`else
    rd_chk("uc_first", 32'hA000_0100, 32'h60DE_0100, 9);
    rd_chk("uc_second", 32'hA000_0100, 32'h60DE_0100, 0);
    for (int w = 0; w < 4; w++) push_exp(1'b0, 32'hA000_0100 + 32'(4*w), 32'h0);
`endif
    check_log("uc_trace", base);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
